// File: rtl/dom_gf16_pkg.sv
// GF(2^4) helpers (polynomial basis, x^4+x+1) and share-layout utilities for
// the DOM square-scale-multiply datapath.
package dom_gf16_pkg;

  localparam logic [4:0] GF16_POLY  = 5'b10011;
  localparam int         SHARES_MIN = 2;
  localparam int         SHARES_MAX = 4;

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? GF16_POLY[3:0] : 4'h0);
    end
    return acc;
  endfunction

  // Squaring is linear in GF(2^4); this is the reduced Frobenius map.
  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
  endfunction

  function automatic logic [3:0] gf16_scale(input logic [3:0] a, input logic [3:0] nu);
    return gf16_mul(a, nu);
  endfunction

  // Bit offset of the 4-bit mask for share pair (i<j), pairs in lexicographic order.
  function automatic int pair_offset(input int i, input int j, input int shares);
    int p;
    p = 0;
    for (int k = 0; k < i; k++) p = p + (shares - 1 - k);
    p = p + (j - i - 1);
    return 4 * p;
  endfunction

endpackage

// File: rtl/dom_gf16_mul_stage.sv
// DOM multiply: every X_i*Y_j product (remasked off-diagonal) is registered
// before the per-domain XOR compression driven on q_o.
module dom_gf16_mul_stage
  import dom_gf16_pkg::*;
#(
  parameter int SHARES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic [4*SHARES-1:0]           x_i,
  input  logic [4*SHARES-1:0]           y_i,
  input  logic [2*SHARES*(SHARES-1)-1:0] z_i,
  output logic [4*SHARES-1:0]           q_o
);

  // term[i][j] lives in domain i; the diagonal is the inner term.
  logic [SHARES-1:0][SHARES-1:0][3:0] term_d;
  logic [SHARES-1:0][SHARES-1:0][3:0] term_q;

  for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
      if (gi == gj) begin : g_inner
        assign term_d[gi][gj] = gf16_mul(x_i[4*gi +: 4], y_i[4*gj +: 4]);
      end else begin : g_cross
        localparam int ZO = pair_offset((gi < gj) ? gi : gj, (gi < gj) ? gj : gi, SHARES);
        assign term_d[gi][gj] = gf16_mul(x_i[4*gi +: 4], y_i[4*gj +: 4]) ^ z_i[ZO +: 4];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      term_q <= '0;
    end else if (load_i) begin
      term_q <= term_d;
    end
  end

  always_comb begin
    q_o = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        q_o[4*i +: 4] = q_o[4*i +: 4] ^ term_q[i][j];
      end
    end
  end

endmodule

// File: rtl/dom_sqscmul_gf16_stream.sv
// Streaming masked GF(2^4) multiply / square-scale-multiply with valid/ready.
// Optional completed-transaction counter on OpCountxDO when DOM_OP_COUNT_EN is defined.
module dom_sqscmul_gf16_stream
  import dom_gf16_pkg::*;
#(
  parameter int         SHARES    = 2,
  parameter int         PIPELINED = 1,
  parameter logic [3:0] NU        = 4'h9
) (
  input  logic                           ClkxCI,
  input  logic                           RstxBI,
  input  logic                           InValidxSI,
  output logic                           InReadyxSO,
  input  logic                           ModexSI,
  input  logic [4*SHARES-1:0]            XxDI,
  input  logic [4*SHARES-1:0]            YxDI,
  input  logic [2*SHARES*(SHARES-1)-1:0] ZxDI,
  output logic                           OutValidxSO,
  input  logic                           OutReadyxSI,
  output logic [4*SHARES-1:0]            QxDO
`ifdef DOM_OP_COUNT_EN
  ,
  output logic [15:0]                    OpCountxDO
`endif
);

  if (SHARES < SHARES_MIN || SHARES > SHARES_MAX) begin : g_bad_shares
    $error("dom_sqscmul_gf16_stream: SHARES must be in 2..4");
  end
  if (PIPELINED != 0 && PIPELINED != 1) begin : g_bad_pipe
    $error("dom_sqscmul_gf16_stream: PIPELINED must be 0 or 1");
  end

  logic                s1_valid_q, s1_valid_d;
  logic                s1_succ_free;
  logic                accept;
  logic [4*SHARES-1:0] lin_d, lin_q;
  logic [4*SHARES-1:0] mul_q;
  logic [4*SHARES-1:0] s1_q;

  // Stage 1 loads whenever it is empty or its successor takes its contents.
  assign InReadyxSO = !RstxBI && (!s1_valid_q || s1_succ_free);
  assign accept     = InValidxSI && InReadyxSO;
  assign s1_valid_d = InReadyxSO ? InValidxSI : s1_valid_q;

  for (genvar gi = 0; gi < SHARES; gi++) begin : g_lin
    assign lin_d[4*gi +: 4] = ModexSI ? gf16_scale(gf16_sq(XxDI[4*gi +: 4] ^ YxDI[4*gi +: 4]), NU)
                                      : 4'h0;
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxBI) begin
      s1_valid_q <= 1'b0;
      lin_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) lin_q <= lin_d;
    end
  end

  // Masks are only consumed on accept, so stalls never reuse randomness.
  dom_gf16_mul_stage #(
    .SHARES (SHARES)
  ) u_mul (
    .clk_i  (ClkxCI),
    .rst_i  (RstxBI),
    .load_i (accept),
    .x_i    (XxDI),
    .y_i    (YxDI),
    .z_i    (ZxDI),
    .q_o    (mul_q)
  );

  assign s1_q = mul_q ^ lin_q;

  if (PIPELINED != 0) begin : g_s2
    logic                s2_valid_q, s2_valid_d;
    logic                s2_load;
    logic [4*SHARES-1:0] s2_q;

    assign s2_load      = !s2_valid_q || OutReadyxSI;
    assign s2_valid_d   = s2_load ? s1_valid_q : s2_valid_q;
    assign s1_succ_free = s2_load;

    always_ff @(posedge ClkxCI) begin
      if (RstxBI) begin
        s2_valid_q <= 1'b0;
        s2_q       <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        if (s2_load && s1_valid_q) s2_q <= s1_q;
      end
    end

    assign OutValidxSO = s2_valid_q;
    assign QxDO        = s2_q;
  end else begin : g_s1_out
    assign s1_succ_free = OutReadyxSI;
    assign OutValidxSO  = s1_valid_q;
    assign QxDO         = s1_q;
  end

`ifdef DOM_OP_COUNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (OutValidxSO && OutReadyxSI && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxBI) op_count_q <= 16'h0000;
    else        op_count_q <= op_count_d;
  end

  assign OpCountxDO = op_count_q;
`endif

endmodule

// File: doc/dom_sqscmul_gf16_stream.md
Name: dom_sqscmul_gf16_stream

Overview:
Streaming, parametrised successor of the masked GF(2^4) square-scale-multiply used in the DOM AES S-box datapath.
- Generalised over share count and pipeline depth.
- Adds a runtime op mode (plain multiply or square-scale-multiply).
- Adds valid/ready handshaking with stall support, so it can sit between buffered stages of the S-box inversion pipeline instead of running free.

Parameters:
SHARES, 2, number of Boolean shares (legal 2..4; elaboration error otherwise)
PIPELINED, 1, 0 = one register stage (resharing only); 1 = extra output register stage
NU, 4'h9, scaling constant for square-scale mode, GF(2^4) element

Ports:
ClkxCI  in  1  clock, rising edge
RstxBI  in  1  synchronous reset, active-high
InValidxSI  in  1  input transaction valid
InReadyxSO  out  1  block can accept input this cycle
ModexSI  in  1  0 = Q = X*Y; 1 = Q = NU*(X^Y)^2 ^ X*Y; sampled with input
XxDI  in  4*SHARES  X shares, share i at [4i+3:4i]
YxDI  in  4*SHARES  Y shares, same layout
ZxDI  in  2*SHARES*(SHARES-1)  fresh randomness, one 4-bit mask per share pair (i<j), pairs in lexicographic order
OutValidxSO  out  1  output shares valid
OutReadyxSI  in  1  downstream accepts output
QxDO  out  4*SHARES  Q shares, same layout

Behaviour:
- Field arithmetic:
  - GF(2^4), polynomial basis, reduction x^4+x+1.
  - Squaring and scaling by NU are linear and computed share-wise.
- DOM multiply:
  - Inner term X_i*Y_i stays in domain i.
  - For each pair i<j, cross terms X_i*Y_j ^ Z_ij go to domain i and X_j*Y_i ^ Z_ij go to domain j.
  - All terms are registered in stage 1 before any cross-domain XOR compression.
- Stage 1 register contents, per domain:
  - the inner term;
  - the remasked cross terms;
  - the linear term NU*(X_i^Y_i)^2, or 0 when the mode is multiply.
- Output compression:
  - Q_i is the XOR of domain i's stage-1 registers.
  - PIPELINED=1: Q_i is registered again in stage 2.
  - PIPELINED=0: QxDO is the combinational XOR of the stage-1 registers.
- Latency: 1+PIPELINED cycles from accept (InValidxSI & InReadyxSO) to OutValidxSO, provided no stall occurs.
- Throughput: one transaction per cycle.
- Handshake:
  - Each stage has a valid flag.
  - A stage loads when it is empty or when its successor consumes this cycle.
  - InReadyxSO = !stage1_valid | stage1_advances. It is combinational; no combinational path exists from InValidxSI to InReadyxSO.
  - Stalled stages hold data and valid unchanged; QxDO stays stable while OutValidxSO=1 and OutReadyxSI=0.
- Randomness: ZxDI is consumed only on an accepted transaction. It must be fresh per accept; masks are never reused on stall.
- Reset:
  - While RstxBI=1: InReadyxSO=0.
  - Next cycle after reset: all valid flags 0, QxDO = 0, OutValidxSO = 0.
  - First cycle after release: InReadyxSO=1.
  - Reset mid-operation discards all in-flight transactions; no partial outputs.
- Boundary conditions:
  - Simultaneous accept and output consume when full: pass-through with no bubble.
  - InValidxSI=0 with a free pipeline inserts a bubble; the data registers may load but valid stays 0.
  - Values on QxDO while OutValidxSO=0 are don't-care, except 0 after reset.

Optional Feature:
Macro DOM_OP_COUNT_EN.
- Defined:
  - Extra output OpCountxDO[15:0] counts completed transactions (OutValidxSO & OutReadyxSI).
  - Saturates at 16'hFFFF; reset to 0.
  - Does not affect the datapath or timing.
- Undefined: the port and counter are absent; interface is as listed above.

Decomposition:
- Package dom_gf16_pkg contains:
  - gf16_mul, gf16_sq and gf16_scale functions;
  - the reduction polynomial constant;
  - the SHARES_MIN/SHARES_MAX bounds;
  - a function mapping pair (i,j) to its ZxDI bit offset.
- Sub-module dom_gf16_mul_stage holds the DOM multiply with stage-1 registers and a load enable. The top adds the linear term, the valid pipeline and the optional stage 2.

Test Plan:
- Tests use SHARES=2, PIPELINED=1, random masks and random ZxDI, with outputs recombined by XOR of shares.
- Reset: hold RstxBI=1 three cycles with InValidxSI=1 -> InReadyxSO=0, OutValidxSO=0 and QxDO=0; first cycle after release InReadyxSO=1.
- Multiply mode: X=3, Y=5, ModexSI=0 -> recombined Q=0xF exactly 2 cycles after accept. Exhaustive over all 256 (X,Y) pairs matches the gf16_mul model.
- Square-scale mode: X=2, Y=0, ModexSI=1 -> Q=0x2. X=0, Y=0 -> Q=0. Exhaustive 256 pairs match NU*(X^Y)^2 ^ X*Y.
- Backpressure: stream 8 transactions with OutReadyxSI low for cycles 3..6 -> no loss, no duplication, in-order results, QxDO stable during stall, InReadyxSO=0 when both stages full.
- Reset mid-stream: assert RstxBI with 2 transactions in flight -> neither appears. Then X=1, Y=7 multiply -> Q=0x7.
- SHARES=3 and PIPELINED=0: X=3, Y=5 multiply -> Q=0xF after 1 cycle. With DOM_OP_COUNT_EN, 300 transactions -> OpCountxDO=300.
